// File: rtl/bin2bcd_seq_pkg.sv
// Shared display-path definitions: converter FSM encoding and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bin2bcd_seq_pkg;

    // Default sizing for a 16-bit CPU result/PC feeding five seg7 digits.
    localparam int BIN_W_DEF  = 16;
    localparam int DIGITS_DEF = 5;

    // Converter FSM encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any BCD nibble >= 5 before the shift.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
// Ports: nib_in - scratch nibble before the shift; nib_out - corrected nibble (max 12, never carries).
module bcd_add3 (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    assign nib_out = (nib_in >= 4'd5) ? (nib_in + 4'd3) : nib_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Latency: done/bcd appear BIN_W cycles after the accepting edge; one conversion per BIN_W+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
// Ports: clk, rst (async, active-high); start/bin request a conversion;
//        busy high from acceptance through the done cycle; done is a one-cycle pulse;
//        bcd holds packed digits (units in [3:0]) until the next conversion completes.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int SCR_W = 4 * DIGITS;
    // ceil(BIN_W * log10(2)) in integer arithmetic.
    localparam int MIN_DIGITS = (BIN_W * 30103 + 99999) / 100000;

    generate
        if (DIGITS < MIN_DIGITS) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    conv_state_t        state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [SCR_W-1:0]   corr;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   bcd_d;
    logic               busy_d, done_d;

    // One corrector per digit of the scratch register.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .nib_in  (scratch_q[4*g +: 4]),
                .nib_out (corr[4*g +: 4])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W - 1);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Correct first, then shift; the binary MSB feeds scratch bit 0.
                {scratch_d, shift_d} = {corr, shift_q} << 1;
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    bcd_d   = scratch_d;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd       <= bcd_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. Sits between the CPU result/PC outputs and the seg7 decoders in the display path. Replaces wide combinational divide/modulo digit extraction with one shift per clock. Holds the last converted digits stable for the display until the next conversion completes.

## Interface
- BIN_W, 16, width of the binary input.
- DIGITS, 5, number of BCD output digits.
  - Must satisfy DIGITS ≥ ceil(BIN_W·log10 2).
  - Smaller values are illegal; the elaboration check fails.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value; sampled on the accepting edge only.
- busy  output  1  high from the cycle after acceptance through the DONE cycle.
- done  output  1  single-cycle pulse; bcd is valid and newly updated.
- bcd  output  4·DIGITS  packed digits, digit 0 (units) in bits [3:0]; held between conversions.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches bin into the shift register, clears the BCD scratch, and loads bit counter = BIN_W−1.
  - Next state is SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT, one step per cycle:
  - Every scratch nibble ≥5 gets +3.
  - Then {scratch, shift} shifts left one bit; the MSB of shift enters scratch bit 0.
  - Counter decrements.
  - On the step where counter = 0, the corrected-and-shifted scratch is written to bcd and the next state is DONE.
- DONE: done=1, busy=1; next state is IDLE unconditionally.
- start outside IDLE (SHIFT or DONE) is ignored and not queued.
- bin changes after acceptance have no effect on the conversion in flight.
- The add-3 correction uses 4-bit arithmetic per nibble. After correction a nibble is at most 12, so no carry leaves a nibble.
- bcd changes only on the DONE-entry edge or on reset.

## Timing
- Reset values, asserted asynchronously: state=IDLE, busy=0, done=0, bcd=0, scratch=0, counter=0.
- Reset mid-conversion aborts the conversion. bcd returns to 0, not to the previous result.
- Acceptance edge E (start=1 in IDLE):
  - busy=1 from E+1.
  - BIN_W shift steps occur at edges E+1 … E+BIN_W.
  - done=1 and new bcd are visible after edge E+BIN_W (16 cycles for BIN_W=16).
  - busy=0 and done=0 after E+BIN_W+1.
- Earliest next acceptance is edge E+BIN_W+2. Maximum throughput is one conversion per BIN_W+2 cycles.
- start held continuously gives back-to-back conversions at exactly that period.
- start=1 on the same edge that reset deasserts is treated as a normal IDLE sample.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- The shared display package holds:
  - the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the BIN_W/DIGITS defaults used by the top level.
- Sub-module bcd_add3: a purely combinational 4-bit nibble corrector (in ≥5 → in+3, else in).
  - Instantiated DIGITS times via generate.
- The counter width is clog2(BIN_W), computed locally.

## Test plan
- Reset, then start with bin=0 → done after 16 cycles, bcd=0x00000. busy high for exactly 17 cycles.
- bin=16'd65535 → bcd=0x65535. bin=16'd1234 → bcd=0x01234. bin=16'd9 → bcd=0x00009 (checks the digit-boundary add-3).
- Convert 4321, then pulse start at cycles 3 and 16 of the conversion with bin=7 → result 0x04321 and a single done pulse.
- start held high with bin stepping 0,1,2,… → one done every 18 cycles; each bcd equals the value sampled at its acceptance edge.
- Assert rst at shift step 8 of converting 999 → all outputs 0 immediately. After release with start=1, bin=42, the result is 0x00042.
- Random sweep of 10 000 values → bcd matches a reference decimal decomposition of bin, and bcd stays stable between done pulses.
